// File: rtl/serial_mod_checker_pkg.sv
// Shared types and constants for the serial modulo checker.
// Channel FSM encoding, reset divisor and default geometry live here.
package serial_mod_checker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int RST_DIV = 5;
    localparam int DEF_CH  = 4;
    localparam int DEF_DW  = 4;
    localparam int DEF_CW  = 16;

endpackage

// File: rtl/serial_mod_checker_if.sv
// Bundle of divisor-load, serial-bit and result signals for the modulo checker.
// The master side drives stimulus; the slave side is the checker.
interface serial_mod_checker_if
    import serial_mod_checker_pkg::*;
#(
    parameter int CH = DEF_CH,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
);
    logic [DW-1:0]    div_in;
    logic             div_load;
    logic [CH-1:0]    bit_in;
    logic [CH-1:0]    bit_vld;
    logic [CH-1:0]    sof;
    logic [CH*DW-1:0] rem_out;
    logic [CH-1:0]    div_ok;
    logic [CH*CW-1:0] bit_cnt;
    logic             cfg_err;

    modport master (
        output div_in, div_load, bit_in, bit_vld, sof,
        input  rem_out, div_ok, bit_cnt, cfg_err
    );

    modport slave (
        input  div_in, div_load, bit_in, bit_vld, sof,
        output rem_out, div_ok, bit_cnt, cfg_err
    );
endinterface

// File: rtl/serial_mod_checker_mod_chan.sv
// One serial channel: running remainder of an MSB-first frame modulo a per-frame divisor.
// Results are registered, one cycle after the sampling edge; no backpressure.
module mod_chan
    import serial_mod_checker_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] gdiv,
    input  logic          bit_in,
    input  logic          bit_vld,
    input  logic          sof,
    output logic [DW-1:0] rem,
    output logic          div_ok,
    output logic [CW-1:0] cnt
);
    chan_state_t   state_q, state_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] cdiv_q, cdiv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   t;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cdiv_q  <= DW'(RST_DIV);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cdiv_q  <= cdiv_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cdiv_d  = cdiv_q;
        cnt_d   = cnt_q;
        // rem < cdiv keeps 2*rem+bit within DW+1 bits and one subtract sufficient
        t       = {rem_q, bit_in};
        if (bit_vld) begin
            if (sof) begin
                state_d = RUN;
                cdiv_d  = gdiv;
                rem_d   = DW'(bit_in);
                cnt_d   = CW'(1);
            end else if (state_q == RUN) begin
                rem_d = (t >= {1'b0, cdiv_q}) ? DW'(t - {1'b0, cdiv_q}) : DW'(t);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    assign rem    = rem_q;
    assign div_ok = (state_q == RUN) && (rem_q == '0);
    assign cnt    = cnt_q;
endmodule

// File: rtl/serial_mod_checker.sv
// Multi-channel serial divisibility checker with a shared, validated divisor register.
// Outputs are registered, one cycle after the sampling edge; no backpressure.
module serial_mod_checker
    import serial_mod_checker_pkg::*;
#(
    parameter int CH = DEF_CH,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input logic                clk,
    input logic                rst,
    serial_mod_checker_if.slave bus
);
    logic [DW-1:0]    gdiv;
    logic             cfg_err_q;
    logic [CH*DW-1:0] rem_w;
    logic [CH-1:0]    ok_w;
    logic [CH*CW-1:0] cnt_w;

    // Divisors below 2 are rejected: gdiv keeps its value and the error sticks until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            gdiv      <= DW'(RST_DIV);
            cfg_err_q <= 1'b0;
        end else if (bus.div_load) begin
            if (bus.div_in >= DW'(2)) begin
                gdiv <= bus.div_in;
            end else begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_chan
        mod_chan #(
            .DW(DW),
            .CW(CW)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .gdiv   (gdiv),
            .bit_in (bus.bit_in[k]),
            .bit_vld(bus.bit_vld[k]),
            .sof    (bus.sof[k]),
            .rem    (rem_w[k*DW +: DW]),
            .div_ok (ok_w[k]),
            .cnt    (cnt_w[k*CW +: CW])
        );
    end

    assign bus.rem_out = rem_w;
    assign bus.div_ok  = ok_w;
    assign bus.bit_cnt = cnt_w;
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: doc/serial_mod_checker.md
SERIAL_MOD_CHECKER -- requirements
Module: serial_mod_checker

Interface
REQ-001 Parameter CH, default 4: number of independent serial channels.
REQ-002 Parameter DW, default 4: divisor and remainder width; divisors 2..2^DW-1 are legal.
REQ-003 Parameter CW, default 16: per-channel bit-count width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 div_in  in  DW  divisor value, sampled when div_load=1.
REQ-007 div_load  in  1  one-cycle strobe that loads div_in into the global divisor register.
REQ-008 bit_in  in  CH  serial data, one bit per channel, MSB first.
REQ-009 bit_vld  in  CH  per-channel qualifier for bit_in.
REQ-010 sof  in  CH  per-channel start of frame; honoured only when the same channel's bit_vld=1.
REQ-011 rem_out  out  CH*DW  per-channel remainder of the frame value so far; channel k occupies bits [k*DW +: DW].
REQ-012 div_ok  out  CH  1 when the channel is in RUN and rem=0.
REQ-013 bit_cnt  out  CH*CW  per-channel count of bits accepted in the current frame, saturating.
REQ-014 cfg_err  out  1  sticky flag, set by an illegal divisor load.

Function
REQ-015 Global divisor register gdiv resets to 5. div_load with div_in>=2 updates it on the next edge.
REQ-016 div_load with div_in of 0 or 1 leaves gdiv unchanged and sets cfg_err; only rst clears cfg_err.
REQ-017 Each channel keeps a snapshot cdiv. cdiv is loaded from gdiv (the pre-update value if div_load is in the same cycle) at that channel's sof; a gdiv change never affects a running frame.
REQ-018 Per-channel FSM states: IDLE, RUN. IDLE->RUN on bit_vld&sof. RUN stays RUN. RUN->RUN with restart on bit_vld&sof. No other transitions except rst.
REQ-019 In IDLE, bit_vld without sof is ignored: no change to rem, bit_cnt or outputs.
REQ-020 Update at sof: rem <= bit_in, i.e. 0 or 1 (always < cdiv because cdiv>=2); bit_cnt <= 1.
REQ-021 Update in RUN on bit_vld without sof: t = 2*rem + bit_in, computed in DW+1 bits; rem <= (t>=cdiv) ? t-cdiv : t; bit_cnt increments and saturates at 2^CW-1.
REQ-022 In RUN with bit_vld=0: rem and bit_cnt hold.
REQ-023 Latency: rem_out, div_ok and bit_cnt reflect an accepted bit on the cycle after the edge that samples it. All outputs are registered or derived only from registers.
REQ-024 div_ok is 0 in IDLE regardless of rem.
REQ-025 Channels are fully independent; simultaneous sof or bit_vld on any subset of channels is legal.

Reset
REQ-026 On rst: gdiv=5; every channel IDLE with cdiv=5, rem=0 and bit_cnt=0; rem_out=0, div_ok=0, bit_cnt=0, cfg_err=0.
REQ-027 rst during a frame aborts it; the inputs present in the rst cycle are discarded; the next frame requires sof.

Structure
REQ-028 A shared package holds the channel state enum (IDLE=0, RUN=1), the reset divisor constant (5), and the default values of CH, DW and CW.
REQ-029 Per-channel logic is one sub-module, mod_chan, instantiated CH times by a generate loop. The top level holds gdiv, cfg_err and the output flattening.

Verification
REQ-030 Default divisor 5, channel 0: bits 1(sof),0,1 -> rem sequence 1,2,0; div_ok=1 after the third bit; bit_cnt=3.
REQ-031 Divisor 5, channel 1: bits 1(sof),1,1,1 (value 15) -> rem 1,3,2,0; div_ok=1 only after the last bit.
REQ-032 Load div_in=3 while channel 0 is mid-frame under divisor 5 -> channel 0 continues mod 5. Channel 2 sof then bits 1,1,0 (value 6) -> rem 1,0,0 with div_ok=1.
REQ-033 div_load with div_in=1 -> cfg_err=1 and gdiv is unchanged (next frame still mod 5); cfg_err stays 1 until rst.
REQ-034 CW=2: run a 5-bit frame -> bit_cnt saturates at 3. Assert rst mid-frame -> all outputs 0 next cycle; bit_vld without sof afterwards is ignored.
REQ-035 All four channels receive sof and bits in the same cycles with different data -> each rem_out slice matches an independent reference model.
